frame_serializer: RTL and testbench
===================================

// Module: frame_serializer
// PURPOSE
//   Transmit-side stage directly downstream of the ecc encoder.
//   Takes one FRAME_SIZE-bit Hamming codeword and shifts it bit-serially onto the single-wire LightIO line.
//   Frame format: start bit, data LSB-first, even parity bit, stop bit.
//   The noisy channel and the receiving deserializer sit after this block.
// PARAMETERS
//   FRAME_SIZE    15  codeword width in bits; equals `FRAME_SIZE
//   CLKS_PER_BIT   4  clock cycles each line bit is held; legal range 1..255
// PORTS
//   clk          input   1           system clock; all state changes on its rising edge
//   rst_n        input   1           asynchronous reset, active low
//   frame_in     input   FRAME_SIZE  codeword from ecc; sampled only on accept
//   frame_valid  input   1           frame_in holds a codeword to send
//   frame_ready  output  1           block can accept a frame this cycle
//   tx_line      output  1           serial line; idle level is 1
//   tx_busy      output  1           a frame is in flight (any state except IDLE)
//   irq          output  1           one-cycle pulse: frame fully transmitted
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state = IDLE; tx_line = 1, frame_ready = 1, tx_busy = 0, irq = 0.
//     - All counters and the shift register are cleared.
//   Handshake:
//     - A frame is accepted on the rising edge where frame_valid && frame_ready.
//     - frame_ready = 1 only in IDLE (registered); frame_in is copied to the shift register at accept.
//     - frame_in may change at any time after accept.
//   States and transitions:
//     IDLE   -> START on accept.
//     START  line 0 for CLKS_PER_BIT cycles -> DATA.
//     DATA   bit i = frame_in[i], i = 0..FRAME_SIZE-1; each bit held CLKS_PER_BIT cycles -> PARITY.
//     PARITY line = ^frame_in (even parity over the data bits), held CLKS_PER_BIT cycles -> STOP.
//     STOP   line 1 for CLKS_PER_BIT cycles -> IDLE.
//   Counters:
//     - bit-period counter: counts 0..CLKS_PER_BIT-1, wraps to 0 and advances a bit at the terminal count.
//     - bit counter: $clog2(FRAME_SIZE) bits, counts 0..FRAME_SIZE-1 in DATA, no wrap beyond that.
//   Timing:
//     - tx_line, tx_busy and frame_ready are registered outputs.
//     - The start bit appears on tx_line in the first cycle after the accept edge.
//     - Line occupancy is exactly (FRAME_SIZE+3)*CLKS_PER_BIT cycles (18*CPB at default).
//   Completion:
//     - irq = 1 for exactly one cycle: the first IDLE cycle after STOP. frame_ready = 1 in that same cycle.
//     - If frame_valid is high in that cycle, the next frame is accepted at once.
//       Back-to-back frames are separated only by their stop bit; no idle gap is inserted.
//   Boundaries:
//     - frame_valid while busy: ignored; no frame is lost, because the upstream holds valid until ready.
//     - CLKS_PER_BIT = 1: one cycle per bit, same state sequence.
//     - rst_n asserted mid-frame: tx_line returns to 1 immediately; the frame is discarded; no irq.
//     - frame_valid high during reset: not accepted until the first edge after rst_n release.
// TESTING
//   1. Reset: hold rst_n=0 for 3 clks -> tx_line=1, frame_ready=1, tx_busy=0, irq=0.
//   2. Single frame: frame_in=15'h4A53, CPB=4 ->
//        line = 0, then bits 1,1,0,0,1,0,1,0,0,1,0,1,0,0,1, parity 1, then 1 (stop); each held 4 clks;
//        irq after 72 clks.
//   3. Parity: frame_in=15'h0000 -> parity bit 0;
//        frame_in=15'h0001 -> parity bit 1; 16 data+parity bit-times checked with a sampling checker.
//   4. Back-to-back: valid held high with 15'h7FFF then 15'h0000 ->
//        second start bit immediately follows the first stop bit; two irq pulses exactly 72 clks apart.
//   5. Busy ignore: change frame_in and pulse frame_valid mid-DATA ->
//        transmitted bits unchanged; frame_ready stays 0.
//   6. Mid-frame reset: rst_n=0 during bit 7 ->
//        tx_line=1 in the same cycle; no irq; the next frame after release is sent intact.

Source files
------------

// File: rtl/frame_serializer.sv
// frame_serializer: shifts one Hamming codeword onto the single-wire LightIO line
// as a start bit, LSB-first data, an even parity bit and a stop bit.
module frame_serializer #(
    parameter int FRAME_SIZE   = 15,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_SIZE-1:0] frame_in,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  tx_line,
    output logic                  tx_busy,
    output logic                  irq
);

    localparam int BCW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    // The IDLE/irq cycle is also the last stop-bit cycle, so STOP itself runs one cycle short.
    localparam logic [7:0] STOP_LAST = (CLKS_PER_BIT > 1) ? 8'(CLKS_PER_BIT - 2) : 8'd0;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_SIZE-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_line_q, tx_line_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  irq_q, irq_d;
    logic                  period_end;
    logic                  frame_done;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        tx_line_d     = tx_line_q;
        tx_busy_d     = tx_busy_q;
        frame_ready_d = frame_ready_q;
        irq_d         = 1'b0;
        frame_done    = 1'b0;
        period_end    = (cnt_q == CNT_LAST);
        cnt_d         = period_end ? 8'd0 : cnt_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (frame_valid && frame_ready_q) begin
                    state_d       = START;
                    shift_d       = frame_in;
                    parity_d      = ^frame_in;
                    bit_cnt_d     = '0;
                    tx_line_d     = 1'b0;
                    tx_busy_d     = 1'b1;
                    frame_ready_d = 1'b0;
                end
            end
            START: begin
                if (period_end) begin
                    state_d   = DATA;
                    tx_line_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            DATA: begin
                if (period_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = PARITY;
                        tx_line_d = parity_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_line_d = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    tx_line_d = 1'b1;
                    if (CLKS_PER_BIT == 1) begin
                        frame_done = 1'b1;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_done) begin
            state_d       = IDLE;
            cnt_d         = 8'd0;
            tx_line_d     = 1'b1;
            tx_busy_d     = 1'b0;
            frame_ready_d = 1'b1;
            irq_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tx_line_q     <= 1'b1;
            tx_busy_q     <= 1'b0;
            frame_ready_q <= 1'b1;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tx_line_q     <= tx_line_d;
            tx_busy_q     <= tx_busy_d;
            frame_ready_q <= frame_ready_d;
            irq_q         <= irq_d;
        end
    end

    assign tx_line     = tx_line_q;
    assign tx_busy     = tx_busy_q;
    assign frame_ready = frame_ready_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: drives codewords into frame_serializer and compares every line
// cycle against a slot-based model of the serial frame.
module tb_frame_serializer;

    localparam int FS         = 15;
    localparam int CPB        = 4;
    localparam int FRAME_CLKS = (FS + 3) * CPB;

    logic          clk;
    logic          rst_n;
    logic [FS-1:0] frame_in;
    logic          frame_valid;
    logic          frame_ready;
    logic          tx_line;
    logic          tx_busy;
    logic          irq;

    logic [FS-1:0] frame_in1;
    logic          frame_valid1;
    logic          frame_ready1;
    logic          tx_line1;
    logic          tx_busy1;
    logic          irq1;

    int checks = 0;
    int passes = 0;

    frame_serializer #(.FRAME_SIZE(FS), .CLKS_PER_BIT(CPB)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .tx_line     (tx_line),
        .tx_busy     (tx_busy),
        .irq         (irq)
    );

    frame_serializer #(.FRAME_SIZE(FS), .CLKS_PER_BIT(1)) u_dut_cpb1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in1),
        .frame_valid (frame_valid1),
        .frame_ready (frame_ready1),
        .tx_line     (tx_line1),
        .tx_busy     (tx_busy1),
        .irq         (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level in a given bit slot: 0 start, 1..FS data LSB-first, FS+1 parity, FS+2 stop.
    function automatic logic model_line(input logic [FS-1:0] f, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= FS) return f[slot-1];
        if (slot == FS + 1) return 1'($countones(f) % 2);
        return 1'b1;
    endfunction

    // Expected {tx_line, tx_busy, frame_ready, irq} in cycle k (1-based) after the accept edge.
    function automatic logic [3:0] model_outputs(input logic [FS-1:0] f, input int k, input int cpb);
        int   total = (FS + 3) * cpb;
        logic done  = (k == total);
        return {model_line(f, (k - 1) / cpb), !done, done, done};
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!frame_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_ready !== 1'b1)
            $display("[TB] FAIL wait_ready: frame_ready=%b after %0d cycles, required 1", frame_ready, n);
        else
            passes++;
    endtask

    task automatic test_reset();
        logic [FS-1:0] f;
        logic [3:0]    obs;
        logic [3:0]    exp;
        rst_n        = 1'b0;
        f            = 15'($urandom);
        frame_in     = f;
        frame_valid  = 1'b1;
        frame_in1    = '0;
        frame_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        obs = {tx_line, tx_busy, frame_ready, irq};
        checks++;
        if (obs !== 4'b1010) $display("[TB] FAIL reset_state: got %b required 1010", obs);
        else passes++;
        obs = {tx_line1, tx_busy1, frame_ready1, irq1};
        checks++;
        if (obs !== 4'b1010) $display("[TB] FAIL reset_state_cpb1: got %b required 1010", obs);
        else passes++;
        rst_n = 1'b1;
        for (int k = 1; k <= FRAME_CLKS; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            exp = model_outputs(f, k, CPB);
            checks++;
            if (obs !== exp) $display("[TB] FAIL accept_after_release k=%0d: got %b required %b", k, obs, exp);
            else passes++;
            if (k == 1) frame_valid = 1'b0;
        end
    endtask

    task automatic test_single_frame();
        logic [FS-1:0] f = 15'h4A53;
        logic [17:0]   seen = '0;
        logic [17:0]   golden;
        logic [3:0]    obs;
        logic [3:0]    exp;
        golden = {1'b1, 1'b1, 15'h4A53, 1'b0};
        wait_ready();
        frame_in    = f;
        frame_valid = 1'b1;
        for (int k = 1; k <= FRAME_CLKS; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            exp = model_outputs(f, k, CPB);
            checks++;
            if (obs !== exp) $display("[TB] FAIL single_frame k=%0d: got %b required %b", k, obs, exp);
            else passes++;
            if ((k - 1) % CPB == CPB / 2) seen[(k - 1) / CPB] = tx_line;
            if (k == 1) begin
                frame_valid = 1'b0;
                frame_in    = ~f;
            end
        end
        checks++;
        if (seen !== golden) $display("[TB] FAIL single_frame_bits: got %b required %b", seen, golden);
        else passes++;
    endtask

    task automatic test_random_frames();
        logic [FS-1:0] f;
        logic [3:0]    obs;
        logic [3:0]    exp;
        for (int n = 0; n < 4; n++) begin
            f = 15'($urandom);
            wait_ready();
            frame_in    = f;
            frame_valid = 1'b1;
            for (int k = 1; k <= FRAME_CLKS; k++) begin
                @(negedge clk);
                obs = {tx_line, tx_busy, frame_ready, irq};
                exp = model_outputs(f, k, CPB);
                checks++;
                if (obs !== exp) $display("[TB] FAIL random_frame %0d k=%0d: got %b required %b", n, k, obs, exp);
                else passes++;
                frame_valid = 1'b0;
                frame_in    = 15'($urandom);
            end
        end
    endtask

    task automatic test_parity();
        logic [FS-1:0] frames [2];
        logic          par_exp [2];
        logic [3:0]    obs;
        logic [3:0]    exp;
        frames[0]  = 15'h0000;
        frames[1]  = 15'h0001;
        par_exp[0] = 1'b0;
        par_exp[1] = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_ready();
            frame_in    = frames[n];
            frame_valid = 1'b1;
            for (int k = 1; k <= FRAME_CLKS; k++) begin
                @(negedge clk);
                obs = {tx_line, tx_busy, frame_ready, irq};
                exp = model_outputs(frames[n], k, CPB);
                checks++;
                if (obs !== exp) $display("[TB] FAIL parity_frame %0d k=%0d: got %b required %b", n, k, obs, exp);
                else passes++;
                if (k == (FS + 1) * CPB + CPB / 2) begin
                    checks++;
                    if (tx_line !== par_exp[n])
                        $display("[TB] FAIL parity_bit %h: got %b required %b", frames[n], tx_line, par_exp[n]);
                    else
                        passes++;
                end
                frame_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [FS-1:0] f1 = 15'h7FFF;
        logic [FS-1:0] f2 = 15'h0000;
        int            irq_k [$];
        logic [3:0]    obs;
        logic [3:0]    exp;
        wait_ready();
        frame_in    = f1;
        frame_valid = 1'b1;
        for (int k = 1; k <= 2 * FRAME_CLKS; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            exp = (k <= FRAME_CLKS) ? model_outputs(f1, k, CPB) : model_outputs(f2, k - FRAME_CLKS, CPB);
            checks++;
            if (obs !== exp) $display("[TB] FAIL back_to_back k=%0d: got %b required %b", k, obs, exp);
            else passes++;
            if (irq) irq_k.push_back(k);
            if (k == 1) frame_in = f2;
            if (k == FRAME_CLKS + 1) frame_valid = 1'b0;
        end
        checks++;
        if (irq_k.size() != 2)
            $display("[TB] FAIL back_to_back_irq_count: got %0d required 2", irq_k.size());
        else if (irq_k[1] - irq_k[0] != FRAME_CLKS)
            $display("[TB] FAIL back_to_back_irq_gap: got %0d required %0d", irq_k[1] - irq_k[0], FRAME_CLKS);
        else
            passes++;
    endtask

    task automatic test_busy_ignore();
        logic [FS-1:0] f = 15'($urandom);
        int            glitch_k = $urandom_range(6 * CPB, 12 * CPB);
        logic [3:0]    obs;
        logic [3:0]    exp;
        wait_ready();
        frame_in    = f;
        frame_valid = 1'b1;
        for (int k = 1; k <= FRAME_CLKS; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            exp = model_outputs(f, k, CPB);
            checks++;
            if (obs !== exp) $display("[TB] FAIL busy_ignore k=%0d: got %b required %b", k, obs, exp);
            else passes++;
            frame_valid = (k == glitch_k);
            if (k == glitch_k) frame_in = ~f;
        end
    endtask

    task automatic test_mid_reset();
        logic [FS-1:0] f  = 15'($urandom);
        logic [FS-1:0] f2 = 15'($urandom);
        logic [3:0]    obs;
        logic [3:0]    exp;
        wait_ready();
        frame_in    = f;
        frame_valid = 1'b1;
        for (int k = 1; k <= 8 * CPB + 2; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            exp = model_outputs(f, k, CPB);
            checks++;
            if (obs !== exp) $display("[TB] FAIL mid_reset_pre k=%0d: got %b required %b", k, obs, exp);
            else passes++;
            frame_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {tx_line, tx_busy, frame_ready, irq};
        checks++;
        if (obs !== 4'b1010) $display("[TB] FAIL mid_reset_immediate: got %b required 1010", obs);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            checks++;
            if (obs !== 4'b1010) $display("[TB] FAIL mid_reset_idle c=%0d: got %b required 1010", k, obs);
            else passes++;
        end
        frame_in    = f2;
        frame_valid = 1'b1;
        for (int k = 1; k <= FRAME_CLKS; k++) begin
            @(negedge clk);
            obs = {tx_line, tx_busy, frame_ready, irq};
            exp = model_outputs(f2, k, CPB);
            checks++;
            if (obs !== exp) $display("[TB] FAIL mid_reset_next k=%0d: got %b required %b", k, obs, exp);
            else passes++;
            frame_valid = 1'b0;
        end
    endtask

    task automatic test_cpb1();
        logic [FS-1:0] frames [2];
        logic [3:0]    obs;
        logic [3:0]    exp;
        frames[0] = 15'h4A53;
        frames[1] = 15'($urandom);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            frame_in1    = frames[n];
            frame_valid1 = 1'b1;
            for (int k = 1; k <= FS + 3; k++) begin
                @(negedge clk);
                obs = {tx_line1, tx_busy1, frame_ready1, irq1};
                exp = model_outputs(frames[n], k, 1);
                checks++;
                if (obs !== exp) $display("[TB] FAIL cpb1_frame %0d k=%0d: got %b required %b", n, k, obs, exp);
                else passes++;
                frame_valid1 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_cpb1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
